mfp_uart_transmitter: RTL and testbench



---
 rtl/mfp_uart_transmitter_pkg.sv | 26 ++
 rtl/mfp_uart_tx_fifo.sv | 64 ++++++
 rtl/mfp_uart_transmitter.sv | 137 +++++++++++++
 tb/tb_mfp_uart_transmitter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_uart_transmitter_pkg.sv
// Shared constants and types for the MFP UART transmitter: frame width,
// default line settings and the transmit FSM state encoding.
package mfp_uart_transmitter_pkg;

    localparam int DATA_W            = 8;
    localparam int DEFAULT_CLK_FREQ  = 50_000_000;
    localparam int DEFAULT_BAUD_RATE = 115_200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Rounded to nearest so odd clock/baud ratios keep the smallest rate error.
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

    // Counter width that stays legal when a count range collapses to one value.
    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Transmit byte queue: power-of-two depth, head visible combinationally so the
// FSM can load its shift register on the same edge that pops.
module mfp_uart_tx_fifo
    import mfp_uart_transmitter_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = DATA_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q];
    assign count   = count_q;

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tells full from empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mfp_uart_transmitter.sv
// 8N1 UART transmitter fed from a byte FIFO; frames are sent back to back
// while bytes remain queued. FIFO_DEPTH must be a power of two, at least 2.
module mfp_uart_transmitter
    import mfp_uart_transmitter_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    output logic                          busy,
    output logic                          tx
);

    localparam int                CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int                BAUD_W       = width_of(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e           state_q;
    logic [BAUD_W-1:0]   baud_q;
    logic [2:0]          bit_idx_q;
    logic [DATA_W-1:0]   shift_q;
    logic                tx_q;
    logic                busy_q;

    logic                fifo_push;
    logic                fifo_pop;
    logic [DATA_W-1:0]   fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic                baud_last;

    assign tx_ready  = !fifo_full;
    assign fifo_push = tx_valid && !fifo_full;
    assign baud_last = (baud_q == BAUD_LAST);
    assign tx        = tx_q;
    assign busy      = busy_q;

    // A pop starts a new frame: from idle, or chained directly off the final stop cycle.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            fifo_pop = (state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_last);
        end
    end

    mfp_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (tx_data),
        .rdata (fifo_rdata),
        .count (tx_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // tx_q is loaded only here, so the line never sees combinational glitches.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    baud_q <= '0;
                    if (fifo_pop) begin
                        shift_q <= fifo_rdata;
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (fifo_pop) begin
                            shift_q <= fifo_rdata;
                            state_q <= ST_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Bench for mfp_uart_transmitter: default-rate and 10-clock-per-bit instances,
// a frame-timing model compared every cycle, a line decoder and a scoreboard.
module tb_mfp_uart_transmitter;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_s [2];
    logic       valid_s [2];
    logic [7:0] data_s  [2];
    logic       ready_w [2];
    logic       busy_w  [2];
    logic       tx_w    [2];
    logic [4:0] cnt_w   [2];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    // Model: queue contents, and the current frame as (byte, cycles since start).
    logic [7:0] m_q   [2][32];
    int         m_head[2];
    int         m_n   [2];
    int         m_pos [2];
    bit         m_act [2];
    logic [7:0] m_cur [2];
    bit         mp_push, mp_start;

    // Scoreboard of accepted bytes and the line decoder state.
    logic [7:0] sb_mem [2][4096];
    int         sb_wr  [2];
    int         sb_rd  [2];
    bit         dec_abort [2];
    int         dec_st  [2];
    int         dec_cnt [2];
    int         dec_b;
    logic [7:0] dec_byte [2];
    logic [7:0] dec_log  [2][8];
    int         dec_n    [2];

    logic [7:0] cmp_act, cmp_exp;

    mfp_uart_transmitter u_dut0 (
        .clock    (clk),
        .reset    (reset_s[0]),
        .tx_data  (data_s[0]),
        .tx_valid (valid_s[0]),
        .tx_ready (ready_w[0]),
        .tx_count (cnt_w[0]),
        .busy     (busy_w[0]),
        .tx       (tx_w[0])
    );

    mfp_uart_transmitter #(
        .CLK_FREQ  (1000),
        .BAUD_RATE (100)
    ) u_dut1 (
        .clock    (clk),
        .reset    (reset_s[1]),
        .tx_data  (data_s[1]),
        .tx_valid (valid_s[1]),
        .tx_ready (ready_w[1]),
        .tx_count (cnt_w[1]),
        .busy     (busy_w[1]),
        .tx       (tx_w[1])
    );

    function automatic int cpb_of(input int k);
        return (k == 0) ? 434 : 10;
    endfunction

    // Line level implied by the frame position: start, d0..d7, stop.
    function automatic logic exp_tx(input int k);
        int b;
        if (!m_act[k]) return 1'b1;
        b = m_pos[k] / cpb_of(k);
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return m_cur[k][b-1];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Model update on each rising edge using the inputs presented before it.
    initial forever begin
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (reset_s[k]) begin
                m_n[k]       = 0;
                m_head[k]    = 0;
                m_act[k]     = 1'b0;
                m_pos[k]     = 0;
                sb_rd[k]     = sb_wr[k];
                dec_abort[k] = 1'b1;
            end else begin
                mp_push  = valid_s[k] && (m_n[k] != DEPTH);
                mp_start = 1'b0;
                if (m_act[k]) begin
                    m_pos[k]++;
                    if (m_pos[k] == 10 * cpb_of(k)) begin
                        if (m_n[k] > 0) mp_start = 1'b1;
                        else            m_act[k] = 1'b0;
                    end
                end else if (m_n[k] > 0) begin
                    mp_start = 1'b1;
                end
                if (mp_start) begin
                    m_cur[k]  = m_q[k][m_head[k]];
                    m_head[k] = (m_head[k] + 1) % 32;
                    m_n[k]--;
                    m_act[k]  = 1'b1;
                    m_pos[k]  = 0;
                end
                if (mp_push) begin
                    m_q[k][(m_head[k] + m_n[k]) % 32] = data_s[k];
                    m_n[k]++;
                    sb_mem[k][sb_wr[k] % 4096] = data_s[k];
                    sb_wr[k]++;
                end
            end
        end
    end

    // Per-cycle output comparison, then mid-bit line decoding.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (cmp_en) begin
                cmp_act = {tx_w[k], busy_w[k], cnt_w[k], ready_w[k]};
                cmp_exp = {exp_tx(k), m_act[k], 5'(m_n[k]), (m_n[k] != DEPTH)};
                n_assert++;
                if (cmp_act !== cmp_exp) begin
                    n_fail++;
                    $display("FAIL cycle %0d dut%0d {tx,busy,count,ready}: got %b_%b_%0d_%b, expected %b_%b_%0d_%b",
                             cyc, k, cmp_act[7], cmp_act[6], cmp_act[5:1], cmp_act[0],
                             cmp_exp[7], cmp_exp[6], cmp_exp[5:1], cmp_exp[0]);
                end
            end
            if (dec_abort[k]) begin
                dec_abort[k] = 1'b0;
                dec_st[k]    = 0;
            end else if (dec_st[k] == 0) begin
                if (cmp_en && tx_w[k] === 1'b0) begin
                    dec_st[k]  = 1;
                    dec_cnt[k] = 0;
                end
            end else begin
                dec_cnt[k]++;
                if (dec_cnt[k] >= cpb_of(k) / 2 && (dec_cnt[k] - cpb_of(k) / 2) % cpb_of(k) == 0) begin
                    dec_b = (dec_cnt[k] - cpb_of(k) / 2) / cpb_of(k);
                    if (dec_b == 0) begin
                        chk($sformatf("dut%0d start bit", k), tx_w[k], 1'b0);
                    end else if (dec_b <= 8) begin
                        dec_byte[k][dec_b-1] = tx_w[k];
                    end else begin
                        chk($sformatf("dut%0d stop bit", k), tx_w[k], 1'b1);
                        if (sb_rd[k] == sb_wr[k]) begin
                            n_assert++;
                            n_fail++;
                            $display("FAIL dut%0d unexpected byte: got 0x%02h, expected no frame", k, dec_byte[k]);
                        end else begin
                            chk($sformatf("dut%0d byte order", k), dec_byte[k], sb_mem[k][sb_rd[k] % 4096]);
                            sb_rd[k]++;
                        end
                        $display("dut%0d rx byte 0x%02h at cycle %0d", k, dec_byte[k], cyc);
                        dec_log[k][dec_n[k] % 8] = dec_byte[k];
                        dec_n[k]++;
                        dec_st[k] = 0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         c;
        int         acc;
        int         guard;
        logic       a5_exp [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        for (int k = 0; k < 2; k++) begin
            reset_s[k] = 1'b1;
            valid_s[k] = 1'b0;
            data_s[k]  = 8'h00;
        end
        tick(1);
        cmp_en = 1'b1;
        tick(2);
        reset_s[0] = 1'b0;
        reset_s[1] = 1'b0;
        tick(1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d reset tx", k), tx_w[k], 1'b1);
            chk($sformatf("dut%0d reset busy", k), busy_w[k], 1'b0);
            chk($sformatf("dut%0d reset count", k), cnt_w[k], 0);
            chk($sformatf("dut%0d reset ready", k), ready_w[k], 1'b1);
        end

        // Single 0xA5 frame at the default bit period.
        c = cyc;
        valid_s[0] = 1'b1;
        data_s[0]  = 8'hA5;
        base = c + 2;
        tick(1);
        valid_s[0] = 1'b0;
        chk("A5 count after accept", cnt_w[0], 1);
        chk("A5 line idle at accept", tx_w[0], 1'b1);
        tick(1);
        chk("A5 start one cycle after accept", tx_w[0], 1'b0);
        chk("A5 busy at start", busy_w[0], 1'b1);
        chk("A5 popped", cnt_w[0], 0);
        for (int b = 0; b < 10; b++) begin
            wait_to(base + b * 434 + 217);
            chk($sformatf("A5 bit %0d", b), tx_w[0], a5_exp[b]);
        end
        wait_to(base + 4339);
        chk("A5 busy last stop cycle", busy_w[0], 1'b1);
        tick(1);
        chk("A5 busy low after 4340", busy_w[0], 1'b0);
        chk("A5 line idle after frame", tx_w[0], 1'b1);

        // Reset in the middle of d3 with three bytes still queued.
        tick(2);
        c = cyc;
        base = c + 2;
        valid_s[0] = 1'b1;
        data_s[0] = 8'h11; tick(1);
        data_s[0] = 8'h22; tick(1);
        data_s[0] = 8'h33; tick(1);
        data_s[0] = 8'h44; tick(1);
        valid_s[0] = 1'b0;
        chk("mid-frame queue depth", cnt_w[0], 3);
        wait_to(base + 4 * 434 + 217);
        chk("0x11 d3 on line", tx_w[0], 1'b0);
        reset_s[0] = 1'b1;
        tick(1);
        reset_s[0] = 1'b0;
        chk("post-reset tx", tx_w[0], 1'b1);
        chk("post-reset busy", busy_w[0], 1'b0);
        chk("post-reset count", cnt_w[0], 0);
        chk("post-reset ready", ready_w[0], 1'b1);
        tick(2500);
        chk("no frame after reset", tx_w[0], 1'b1);
        chk("idle after reset", busy_w[0], 1'b0);

        // 0x00 then 0xFF at 10 clocks per bit: exact boundaries, zero gap.
        c = cyc;
        base = c + 2;
        valid_s[1] = 1'b1;
        data_s[1] = 8'h00; tick(1);
        data_s[1] = 8'hFF; tick(1);
        valid_s[1] = 1'b0;
        wait_to(base + 89);  chk("0x00 d7 last cycle", tx_w[1], 1'b0);
        wait_to(base + 90);  chk("0x00 stop first cycle", tx_w[1], 1'b1);
        wait_to(base + 99);  chk("0x00 stop last cycle", tx_w[1], 1'b1);
        wait_to(base + 100); chk("0xFF start no gap", tx_w[1], 1'b0);
        wait_to(base + 109); chk("0xFF start last cycle", tx_w[1], 1'b0);
        wait_to(base + 110); chk("0xFF d0 first cycle", tx_w[1], 1'b1);
        wait_to(base + 199); chk("0xFF busy last cycle", busy_w[1], 1'b1);
        wait_to(base + 200); chk("0xFF busy low", busy_w[1], 1'b0);
        wait_to(base + 205);
        chk("decoded count", dec_n[1], 2);
        chk("decoded first", dec_log[1][0], 8'h00);
        chk("decoded second", dec_log[1][1], 8'hFF);

        // Burst of 17 while the line is busy, then push against full during a pop.
        tick(5);
        c = cyc;
        base = c + 2;
        valid_s[1] = 1'b1;
        data_s[1]  = 8'h55;
        tick(1);
        valid_s[1] = 1'b0;
        tick(1);
        for (int i = 0; i < 17; i++) begin
            valid_s[1] = 1'b1;
            data_s[1]  = 8'(8'h60 + i);
            if (i == 16) begin
                chk("burst full count", cnt_w[1], 16);
                chk("burst ready low", ready_w[1], 1'b0);
            end
            tick(1);
        end
        valid_s[1] = 1'b0;
        chk("17th byte refused", cnt_w[1], 16);
        wait_to(base + 99);
        valid_s[1] = 1'b1;
        data_s[1]  = 8'hEE;
        chk("full before pop", cnt_w[1], 16);
        chk("ready low before pop", ready_w[1], 1'b0);
        tick(1);
        valid_s[1] = 1'b0;
        chk("pop while full", cnt_w[1], 15);
        chk("next start no gap", tx_w[1], 1'b0);
        wait_to(base + 1710);
        chk("burst drained", sb_wr[1] - sb_rd[1], 0);
        chk("burst idle", busy_w[1], 1'b0);

        // 200 bytes with a random valid pattern.
        acc = 0;
        guard = 0;
        while (acc < 200 && guard < 40000) begin
            valid_s[1] = ($urandom_range(0, 3) != 0);
            data_s[1]  = 8'($urandom);
            if (valid_s[1] && ready_w[1]) acc++;
            tick(1);
            guard++;
        end
        valid_s[1] = 1'b0;
        chk("random bytes accepted", acc, 200);
        guard = 0;
        while (sb_rd[1] != sb_wr[1] && guard < 3000) begin
            tick(1);
            guard++;
        end
        tick(20);
        chk("random stream drained", sb_wr[1] - sb_rd[1], 0);
        chk("random idle", busy_w[1], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
